// File: rtl/bus_block_copier_pkg.sv
// Shared definitions for the bus block copier: bus access sizes, data width
// and the copier's state encoding.
package bus_block_copier_pkg;

  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;

  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  typedef enum logic [2:0] {
    BCP_ST_IDLE    = 3'd0,
    BCP_ST_RD_REQ  = 3'd1,
    BCP_ST_RD_WAIT = 3'd2,
    BCP_ST_WR_REQ  = 3'd3,
    BCP_ST_WR_WAIT = 3'd4,
    BCP_ST_FIN     = 3'd5
  } bcp_state_e;

  // A word access needs the two low byte-address bits clear.
  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/bus_block_copier.sv
// Bus initiator copying a block of 32-bit words from one address range to
// another, one read followed by one write per word.
module bus_block_copier
  import bus_block_copier_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    src,
  input  logic [ADDR_WIDTH-1:0]    dst,
  input  logic [LEN_WIDTH-1:0]     len,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ADDR_WIDTH-1:0]    err_addr,
  output logic [ADDR_WIDTH-1:0]    bus_addr,
  output logic                     bus_w_rb,
  output logic [BUS_ACC_WIDTH-1:0] bus_acc,
  output logic [BUS_WIDTH-1:0]     bus_wdata,
  output logic                     bus_req,
  input  logic [BUS_WIDTH-1:0]     bus_rdata,
  input  logic                     bus_resp,
  input  logic                     bus_fault
);

  localparam int CNT_WIDTH = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The wait is abandoned on the TIMEOUT-th consecutive cycle without resp.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

  bcp_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cur_src_q, cur_src_d;
  logic [ADDR_WIDTH-1:0]  cur_dst_q, cur_dst_d;
  logic [LEN_WIDTH-1:0]   remain_q, remain_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;
  logic [ADDR_WIDTH-1:0]  bus_addr_q, bus_addr_d;
  logic                   bus_w_rb_q, bus_w_rb_d;
  logic [BUS_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
  logic                   bus_req_q, bus_req_d;
  logic [ADDR_WIDTH-1:0]  next_src, next_dst;

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign bus_addr  = bus_addr_q;
  assign bus_w_rb  = bus_w_rb_q;
  assign bus_acc   = BUS_ACC_4B;
  assign bus_wdata = bus_wdata_q;
  assign bus_req   = bus_req_q;

  assign next_src = cur_src_q + WORD_STEP;
  assign next_dst = cur_dst_q + WORD_STEP;

  // Next-state logic; bus outputs are set up on entry to a REQ state so the
  // registered bus_req pulse and its qualifiers appear together for one cycle.
  // bus_wdata_q doubles as the data register holding the word being moved.
  always_comb begin
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    cur_dst_d   = cur_dst_q;
    remain_d    = remain_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    bus_addr_d  = bus_addr_q;
    bus_w_rb_d  = bus_w_rb_q;
    bus_wdata_d = bus_wdata_q;
    bus_req_d   = 1'b0;

    unique case (state_q)
      BCP_ST_IDLE: begin
        if (start) begin
          cur_src_d = src;
          cur_dst_d = dst;
          remain_d  = len;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          if (is_misaligned(src[1:0])) begin
            err_d      = 1'b1;
            err_addr_d = src;
            state_d    = BCP_ST_FIN;
          end else if (is_misaligned(dst[1:0])) begin
            err_d      = 1'b1;
            err_addr_d = dst;
            state_d    = BCP_ST_FIN;
          end else if (len == '0) begin
            done_d  = 1'b1;
            state_d = BCP_ST_FIN;
          end else begin
            bus_req_d  = 1'b1;
            bus_w_rb_d = 1'b0;
            bus_addr_d = src;
            state_d    = BCP_ST_RD_REQ;
          end
        end
      end

      BCP_ST_RD_REQ: begin
        if (bus_fault) begin
          err_d      = 1'b1;
          err_addr_d = cur_src_q;
          state_d    = BCP_ST_FIN;
        end else begin
          cnt_d   = '0;
          state_d = BCP_ST_RD_WAIT;
        end
      end

      BCP_ST_RD_WAIT: begin
        if (bus_resp) begin
          bus_wdata_d = bus_rdata;
          bus_req_d   = 1'b1;
          bus_w_rb_d  = 1'b1;
          bus_addr_d  = cur_dst_q;
          state_d     = BCP_ST_WR_REQ;
        end else if (cnt_q == CNT_LAST) begin
          err_d      = 1'b1;
          err_addr_d = cur_src_q;
          state_d    = BCP_ST_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      BCP_ST_WR_REQ: begin
        if (bus_fault) begin
          err_d      = 1'b1;
          err_addr_d = cur_dst_q;
          state_d    = BCP_ST_FIN;
        end else begin
          cnt_d   = '0;
          state_d = BCP_ST_WR_WAIT;
        end
      end

      BCP_ST_WR_WAIT: begin
        if (bus_resp) begin
          cur_src_d = next_src;
          cur_dst_d = next_dst;
          remain_d  = remain_q - LEN_ONE;
          if (remain_q == LEN_ONE) begin
            done_d  = 1'b1;
            state_d = BCP_ST_FIN;
          end else begin
            bus_req_d  = 1'b1;
            bus_w_rb_d = 1'b0;
            bus_addr_d = next_src;
            state_d    = BCP_ST_RD_REQ;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d      = 1'b1;
          err_addr_d = cur_dst_q;
          state_d    = BCP_ST_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      BCP_ST_FIN: begin
        busy_d  = 1'b0;
        state_d = BCP_ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = BCP_ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any copy in flight at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BCP_ST_IDLE;
      cur_src_q   <= '0;
      cur_dst_q   <= '0;
      remain_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      bus_addr_q  <= '0;
      bus_w_rb_q  <= 1'b0;
      bus_wdata_q <= '0;
      bus_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      cur_dst_q   <= cur_dst_d;
      remain_q    <= remain_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      bus_addr_q  <= bus_addr_d;
      bus_w_rb_q  <= bus_w_rb_d;
      bus_wdata_q <= bus_wdata_d;
      bus_req_q   <= bus_req_d;
    end
  end

endmodule

// File: tb/tb_bus_block_copier.sv
// Testbench for bus_block_copier: a negedge bus responder with a read image
// and a separate write store, an access log, and scenario tasks that compare
// the log against expectations derived from the copy rules.
module tb_bus_block_copier;
  import bus_block_copier_pkg::*;

  localparam int TO = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [31:0]              src, dst;
  logic [15:0]              len;
  logic                     busy, done, err;
  logic [31:0]              err_addr, bus_addr, bus_wdata;
  logic                     bus_w_rb, bus_req;
  logic [BUS_ACC_WIDTH-1:0] bus_acc;
  logic [31:0]              bus_rdata = 32'h0;
  logic                     bus_resp  = 1'b0;
  logic                     bus_fault = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit resp_en      = 1'b1;
  bit fault_rom_wr = 1'b0;
  logic [31:0] mem  [logic [31:0]];
  logic [31:0] wmem [logic [31:0]];

  int          acc_cyc  [$];
  bit          acc_w    [$];
  logic [31:0] acc_addr [$];
  logic [31:0] acc_data [$];
  int          done_cyc [$];
  int          errfin_cyc [$];
  int          busyfall_cyc [$];

  bit          pend      = 1'b0;
  logic [31:0] pend_data = 32'h0;
  bit          busy_prev = 1'b0;

  bus_block_copier #(
    .ADDR_WIDTH(32),
    .LEN_WIDTH (16),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_addr (err_addr),
    .bus_addr (bus_addr),
    .bus_w_rb (bus_w_rb),
    .bus_acc  (bus_acc),
    .bus_wdata(bus_wdata),
    .bus_req  (bus_req),
    .bus_rdata(bus_rdata),
    .bus_resp (bus_resp),
    .bus_fault(bus_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder (1-cycle resp, optional write fault below 0x1000_0000) and log.
  always @(negedge clk) begin
    bus_resp  = 1'b0;
    bus_fault = 1'b0;
    if (pend) begin
      bus_resp  = 1'b1;
      bus_rdata = pend_data;
      pend      = 1'b0;
    end
    if (bus_req === 1'b1) begin
      acc_cyc.push_back(cyc);
      acc_w.push_back(bus_w_rb);
      acc_addr.push_back(bus_addr);
      acc_data.push_back(bus_wdata);
      if (bus_w_rb && fault_rom_wr && bus_addr < 32'h1000_0000) begin
        bus_fault = 1'b1;
      end else if (resp_en) begin
        pend = 1'b1;
        if (bus_w_rb) wmem[bus_addr] = bus_wdata;
        else pend_data = mem.exists(bus_addr) ? mem[bus_addr] : 32'hDEAD_BEEF;
      end
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (err === 1'b1 && busy === 1'b1) errfin_cyc.push_back(cyc);
    if (busy_prev && busy === 1'b0) busyfall_cyc.push_back(cyc);
    busy_prev = (busy === 1'b1);
  end

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] l, output int c0);
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bus_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: busy=%b done=%b err=%b req=%b, required all 0", busy, done, err, bus_req);
    end
    total++;
    if (err_addr !== 32'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_w_rb !== 1'b0) begin
      bad++;
      $display("FAIL reset_bus: err_addr=%h addr=%h wdata=%h w_rb=%b, required zeros", err_addr, bus_addr, bus_wdata, bus_w_rb);
    end
    total++;
    if (bus_acc !== BUS_ACC_4B) begin
      bad++;
      $display("FAIL reset_acc: got %0d, required %0d", bus_acc, BUS_ACC_4B);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_len();
    int c0, a0, dn0, dc;
    bit ok;
    a0 = acc_cyc.size(); dn0 = done_cyc.size();
    start_copy(32'h40, 32'h2000_0040, 16'd0, c0);
    wait_idle(10, ok);
    dc = (done_cyc.size() > dn0) ? done_cyc[dn0] - c0 : -1;
    total++;
    if (!ok || done_cyc.size() - dn0 != 1 || dc != 1) begin
      bad++;
      $display("FAIL zero_len_done: pulses=%0d at cycle %0d, required 1 at cycle 1", done_cyc.size() - dn0, dc);
    end
    total++;
    if (acc_cyc.size() != a0 || err !== 1'b0) begin
      bad++;
      $display("FAIL zero_len_bus: accesses=%0d err=%b, required 0 and 0", acc_cyc.size() - a0, err);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] s, d, exp_ea;
    int c0, a0, dn0, e0, b0, ec, bc;
    bit ok;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0:       begin s = 32'h0000_0002; d = 32'h2000_0000; end
        1:       begin s = 32'h0000_0001; d = 32'h2000_0002; end
        default: begin s = 32'h0000_0004; d = 32'h2000_0006; end
      endcase
      exp_ea = (s[1:0] != 2'b00) ? s : d;
      a0 = acc_cyc.size(); dn0 = done_cyc.size(); e0 = errfin_cyc.size(); b0 = busyfall_cyc.size();
      start_copy(s, d, 16'd1, c0);
      wait_idle(10, ok);
      ec = (errfin_cyc.size() > e0) ? errfin_cyc[e0] - c0 : -1;
      bc = (busyfall_cyc.size() > b0) ? busyfall_cyc[b0] - c0 : -1;
      total++;
      if (!ok || ec != 1 || err !== 1'b1 || err_addr !== exp_ea) begin
        bad++;
        $display("FAIL misaligned%0d_err: err_cycle=%0d err=%b err_addr=%h, required cycle 1, err 1, addr %h", t, ec, err, err_addr, exp_ea);
      end
      total++;
      if (acc_cyc.size() != a0 || done_cyc.size() != dn0 || bc != 2) begin
        bad++;
        $display("FAIL misaligned%0d_quiet: accesses=%0d done=%0d busy_fall=%0d, required 0, 0, 2", t, acc_cyc.size() - a0, done_cyc.size() - dn0, bc);
      end
    end
  endtask

  task automatic test_copies();
    logic [31:0] s, d, r, word, exp_a, got;
    logic [15:0] l;
    bit exp_w, ok;
    int c0, a0, dn0, e0, b0, n, dc, bc;
    logic [31:0] exp_data [$];
    for (int it = 0; it < 7; it++) begin
      if (it == 0) begin
        s = 32'h0; d = 32'h2000_0000; l = 16'd4;
      end else if (it == 1) begin
        s = 32'hFFFF_FFF8; d = 32'hFFFF_FFF4; l = 16'd3;
      end else begin
        r = $urandom; s = r & 32'h0FFF_FFFC;
        r = $urandom; d = 32'h2000_0000 | (r & 32'h0FFF_FFFC);
        l = 16'($urandom_range(1, 6));
      end
      n = int'(l);
      exp_data.delete();
      for (int i = 0; i < n; i++) begin
        word = (it == 0) ? 32'h1111_1111 * 32'(i + 1) : $urandom;
        mem[s + 32'(4 * i)] = word;
        exp_data.push_back(word);
      end
      a0 = acc_cyc.size(); dn0 = done_cyc.size(); e0 = errfin_cyc.size(); b0 = busyfall_cyc.size();
      start_copy(s, d, l, c0);
      wait_idle(4 * n + 20, ok);
      total++;
      if (!ok || acc_cyc.size() - a0 != 2 * n) begin
        bad++;
        $display("FAIL copy%0d_count: idle=%b accesses=%0d, required idle and %0d", it, ok, acc_cyc.size() - a0, 2 * n);
      end
      for (int k = 0; k < 2 * n && a0 + k < acc_cyc.size(); k++) begin
        exp_w = (k % 2) == 1;
        exp_a = exp_w ? d + 32'(4 * (k / 2)) : s + 32'(4 * (k / 2));
        total++;
        if (acc_w[a0 + k] !== exp_w || acc_addr[a0 + k] !== exp_a ||
            (exp_w && acc_data[a0 + k] !== exp_data[k / 2]) || acc_cyc[a0 + k] - c0 != 2 * k + 1) begin
          bad++;
          $display("FAIL copy%0d_acc%0d: w=%b addr=%h data=%h cycle=%0d, required w=%b addr=%h data=%h cycle=%0d",
                   it, k, acc_w[a0 + k], acc_addr[a0 + k], acc_data[a0 + k], acc_cyc[a0 + k] - c0,
                   exp_w, exp_a, exp_data[k / 2], 2 * k + 1);
        end
      end
      for (int i = 0; i < n; i++) begin
        got = wmem.exists(d + 32'(4 * i)) ? wmem[d + 32'(4 * i)] : 32'hxxxx_xxxx;
        total++;
        if (got !== exp_data[i]) begin
          bad++;
          $display("FAIL copy%0d_ram%0d: got %h, required %h", it, i, got, exp_data[i]);
        end
      end
      dc = (done_cyc.size() > dn0) ? done_cyc[dn0] - c0 : -1;
      bc = (busyfall_cyc.size() > b0) ? busyfall_cyc[b0] - c0 : -1;
      total++;
      if (done_cyc.size() - dn0 != 1 || dc != 4 * n + 1 || bc != 4 * n + 2) begin
        bad++;
        $display("FAIL copy%0d_timing: done pulses=%0d at %0d, busy fall %0d, required 1 at %0d, fall %0d",
                 it, done_cyc.size() - dn0, dc, bc, 4 * n + 1, 4 * n + 2);
      end
      total++;
      if (err !== 1'b0 || errfin_cyc.size() != e0) begin
        bad++;
        $display("FAIL copy%0d_err: err=%b error finishes=%0d, required 0 and 0", it, err, errfin_cyc.size() - e0);
      end
    end
  endtask

  task automatic test_write_fault();
    logic [31:0] w0;
    int c0, a0, dn0, e0, ec;
    bit ok;
    fault_rom_wr = 1'b1;
    w0 = $urandom;
    mem[32'h2000_0000] = w0;
    mem[32'h2000_0004] = $urandom;
    a0 = acc_cyc.size(); dn0 = done_cyc.size(); e0 = errfin_cyc.size();
    start_copy(32'h2000_0000, 32'h0000_0010, 16'd2, c0);
    wait_idle(20, ok);
    total++;
    if (!ok || acc_cyc.size() - a0 != 2) begin
      bad++;
      $display("FAIL wfault_count: idle=%b accesses=%0d, required idle and 2", ok, acc_cyc.size() - a0);
    end else begin
      total++;
      if (acc_w[a0] !== 1'b0 || acc_addr[a0] !== 32'h2000_0000 || acc_w[a0 + 1] !== 1'b1 ||
          acc_addr[a0 + 1] !== 32'h10 || acc_data[a0 + 1] !== w0) begin
        bad++;
        $display("FAIL wfault_seq: rd %b@%h wr %b@%h data %h, required 0@20000000 1@00000010 data %h",
                 acc_w[a0], acc_addr[a0], acc_w[a0 + 1], acc_addr[a0 + 1], acc_data[a0 + 1], w0);
      end
    end
    ec = (errfin_cyc.size() > e0) ? errfin_cyc[e0] - c0 : -1;
    total++;
    if (err !== 1'b1 || err_addr !== 32'h10 || ec != 4 || done_cyc.size() != dn0) begin
      bad++;
      $display("FAIL wfault_err: err=%b err_addr=%h err_cycle=%0d done=%0d, required 1, 00000010, 4, 0",
               err, err_addr, ec, done_cyc.size() - dn0);
    end
    fault_rom_wr = 1'b0;
  endtask

  task automatic test_timeout();
    int c0, a0, dn0, e0, b0, ec, bc;
    bit ok;
    resp_en = 1'b0;
    a0 = acc_cyc.size(); dn0 = done_cyc.size(); e0 = errfin_cyc.size(); b0 = busyfall_cyc.size();
    start_copy(32'h0000_0100, 32'h2000_0100, 16'd2, c0);
    wait_idle(60, ok);
    ec = (errfin_cyc.size() > e0) ? errfin_cyc[e0] - c0 : -1;
    bc = (busyfall_cyc.size() > b0) ? busyfall_cyc[b0] - c0 : -1;
    total++;
    if (!ok || acc_cyc.size() - a0 != 1 || done_cyc.size() != dn0) begin
      bad++;
      $display("FAIL timeout_bus: idle=%b accesses=%0d done=%0d, required idle, 1, 0", ok, acc_cyc.size() - a0, done_cyc.size() - dn0);
    end
    total++;
    if (err !== 1'b1 || err_addr !== 32'h100 || ec != 1 + TO + 1 || bc != 1 + TO + 2) begin
      bad++;
      $display("FAIL timeout_err: err=%b err_addr=%h err_cycle=%0d busy_fall=%0d, required 1, 00000100, %0d, %0d",
               err, err_addr, ec, bc, 1 + TO + 1, 1 + TO + 2);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_reset_mid_copy();
    logic [31:0] w;
    int c0, a0, dn0, e0, dc;
    bit ok;
    for (int i = 0; i < 4; i++) mem[32'h200 + 32'(4 * i)] = $urandom;
    a0 = acc_cyc.size();
    start_copy(32'h200, 32'h2000_0200, 16'd4, c0);
    repeat (7) @(negedge clk);
    total++;
    if (acc_cyc.size() - a0 != 4 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_progress: accesses=%0d busy=%b, required 4 and 1", acc_cyc.size() - a0, busy);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bus_req !== 1'b0 || err_addr !== 32'h0 ||
        bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_w_rb !== 1'b0 || bus_acc !== BUS_ACC_4B) begin
      bad++;
      $display("FAIL rstmid_outputs: busy=%b done=%b err=%b req=%b ea=%h addr=%h wdata=%h w_rb=%b, required reset values",
               busy, done, err, bus_req, err_addr, bus_addr, bus_wdata, bus_w_rb);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (acc_cyc.size() - a0 != 4 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_quiet: accesses=%0d busy=%b, required 4 and 0", acc_cyc.size() - a0, busy);
    end
    w = $urandom;
    mem[32'h300] = w;
    a0 = acc_cyc.size(); dn0 = done_cyc.size(); e0 = errfin_cyc.size();
    start_copy(32'h300, 32'h2000_0300, 16'd1, c0);
    wait_idle(20, ok);
    dc = (done_cyc.size() > dn0) ? done_cyc[dn0] - c0 : -1;
    total++;
    if (!ok || acc_cyc.size() - a0 != 2 || dc != 5 || err !== 1'b0 || errfin_cyc.size() != e0) begin
      bad++;
      $display("FAIL rstmid_restart: accesses=%0d done_cycle=%0d err=%b, required 2, 5, 0", acc_cyc.size() - a0, dc, err);
    end
    total++;
    if (!wmem.exists(32'h2000_0300) || wmem[32'h2000_0300] !== w) begin
      bad++;
      $display("FAIL rstmid_ram: got %h, required %h", wmem.exists(32'h2000_0300) ? wmem[32'h2000_0300] : 32'h0, w);
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] w0, w1;
    int c0, a0, dn0, e0, dc;
    bit ok;
    w0 = $urandom; w1 = $urandom;
    mem[32'h400] = w0; mem[32'h404] = w1;
    a0 = acc_cyc.size(); dn0 = done_cyc.size(); e0 = errfin_cyc.size();
    start_copy(32'h400, 32'h2000_0400, 16'd2, c0);
    repeat (2) @(negedge clk);
    src = 32'h800; dst = 32'h2000_0800; len = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL busy_start_done_wait: done=%b, required 1 within 40 cycles", done);
    end
    src = 32'h2; dst = 32'h2000_0000; len = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(20, ok);
    repeat (3) @(negedge clk);
    #1;
    dc = (done_cyc.size() > dn0) ? done_cyc[dn0] - c0 : -1;
    total++;
    if (acc_cyc.size() - a0 != 4 || done_cyc.size() - dn0 != 1 || dc != 9) begin
      bad++;
      $display("FAIL busy_start_ignored: accesses=%0d done pulses=%0d at %0d, required 4, 1 at 9",
               acc_cyc.size() - a0, done_cyc.size() - dn0, dc);
    end
    total++;
    if (err !== 1'b0 || errfin_cyc.size() != e0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL fin_start_ignored: err=%b error finishes=%0d busy=%b, required 0, 0, 0", err, errfin_cyc.size() - e0, busy);
    end
    total++;
    if (!wmem.exists(32'h2000_0404) || wmem[32'h2000_0404] !== w1 || wmem[32'h2000_0400] !== w0) begin
      bad++;
      $display("FAIL busy_start_ram: got %h %h, required %h %h", wmem[32'h2000_0400],
               wmem.exists(32'h2000_0404) ? wmem[32'h2000_0404] : 32'h0, w0, w1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    test_reset();
    test_zero_len();
    test_misaligned();
    test_copies();
    test_write_fault();
    test_timeout();
    test_reset_mid_copy();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
